// File: rtl/rr_merge_arbiter_pkg.sv
// Shared definitions for the merge and class-demux arbiters: FSM encodings
// and the default word width.
package rr_merge_arbiter_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_merge_arbiter_pick4.sv
// Combinational 4-way rotating priority picker: the search starts at ptr and
// wraps modulo 4; the first requesting slot wins.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    idx     = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_merge_arbiter.sv
// Round-robin merge of four class FIFOs into one merge FIFO, with a 2-cycle
// pop-to-push pipeline and per-class push counters.
module rr_merge_arbiter
  import rr_merge_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            empty,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  almost_full_out,
  output logic [3:0]            pop,
  output logic                  push_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            state,
  output logic [CNT_WIDTH-1:0]  cnt0,
  output logic [CNT_WIDTH-1:0]  cnt1,
  output logic [CNT_WIDTH-1:0]  cnt2,
  output logic [CNT_WIDTH-1:0]  cnt3
);

  arb_state_t            state_q;
  logic [1:0]            ptr;
  logic [3:0]            gnt;
  logic [1:0]            gnt_idx;
  logic                  rd_valid;
  logic [1:0]            rd_idx;
  logic [DATA_WIDTH-1:0] din_sel;
  logic [CNT_WIDTH-1:0]  cnt_q [4];
  logic                  any_ready;

  assign any_ready = ~&empty;

  rr_pick4 u_pick (
    .req     (~empty),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Pop is independent of the FSM state so back-pressure takes effect in the
  // same cycle it is seen, not one cycle later.
  always_comb begin
    pop = '0;
    if (!reset && !almost_full_out) pop = gnt;
  end

  always_comb begin
    din_sel = data_in0;
    case (rd_idx)
      2'd1:    din_sel = data_in1;
      2'd2:    din_sel = data_in2;
      2'd3:    din_sel = data_in3;
      default: din_sel = data_in0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      push_out <= 1'b0;
      data_out <= '0;
      for (int unsigned k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      if (|pop) ptr <= gnt_idx + 2'd1;
      rd_valid <= |pop;
      rd_idx   <= gnt_idx;
      push_out <= rd_valid;
      if (rd_valid) begin
        data_out       <= din_sel;
        cnt_q[rd_idx]  <= cnt_q[rd_idx] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (any_ready) state_q <= almost_full_out ? STALL : ACTIVE;
        ACTIVE: begin
          if (almost_full_out)  state_q <= STALL;
          else if (!any_ready)  state_q <= IDLE;
        end
        STALL:   if (!almost_full_out) state_q <= any_ready ? ACTIVE : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state = state_q;
  assign cnt0  = cnt_q[0];
  assign cnt1  = cnt_q[1];
  assign cnt2  = cnt_q[2];
  assign cnt3  = cnt_q[3];

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// Scoreboard bench for rr_merge_arbiter: behavioural class FIFOs, a reference
// round-robin/FSM model, and a queue of expected pushes with due cycles.
module tb_rr_merge_arbiter;

  localparam int DW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          af;
  logic [3:0]    empty;
  logic [DW-1:0] din [4];
  logic [3:0]    pop;
  logic          push_out;
  logic [DW-1:0] data_out;
  logic [1:0]    state;
  logic [CW-1:0] cnt_o [4];

  rr_merge_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .empty           (empty),
    .data_in0        (din[0]),
    .data_in1        (din[1]),
    .data_in2        (din[2]),
    .data_in3        (din[3]),
    .almost_full_out (af),
    .pop             (pop),
    .push_out        (push_out),
    .data_out        (data_out),
    .state           (state),
    .cnt0            (cnt_o[0]),
    .cnt1            (cnt_o[1]),
    .cnt2            (cnt_o[2]),
    .cnt3            (cnt_o[3])
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cls;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] fq [4][$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            mptr = 0;
  int            mstate = 0;
  logic [CW-1:0] mcnt [4];
  logic [DW-1:0] last_data = '0;
  logic [3:0]    last_pop;
  int            push_seen = 0;

  task automatic upd_empty();
    for (int i = 0; i < 4; i++) empty[i] = (fq[i].size() == 0);
  endtask

  task automatic load(input int k, input logic [DW-1:0] w);
    fq[k].push_back(w);
    upd_empty();
  endtask

  // One clock cycle: check outputs, advance the reference model, then model
  // the class FIFOs' one-cycle read latency just after the edge.
  task automatic tick();
    logic [3:0] ep;
    int         eidx;
    logic [3:0] ps;
    logic       due;
    exp_t       e;
    logic       any;
    #1;
    ep = '0;
    eidx = 0;
    if (!reset && !af) begin
      for (int i = 0; i < 4; i++) begin
        int idx;
        idx = (mptr + i) % 4;
        if (!empty[idx] && ep == 4'd0) begin
          ep[idx] = 1'b1;
          eidx = idx;
        end
      end
    end
    checks++;
    if (pop !== ep) begin
      errors++;
      $display("FAIL pop cyc=%0d got=%b want=%b", cyc, pop, ep);
    end
    checks++;
    if (state !== 2'(mstate)) begin
      errors++;
      $display("FAIL state cyc=%0d got=%0d want=%0d", cyc, state, mstate);
    end
    due = (sb.size() > 0) && (sb[0].due == cyc);
    checks++;
    if (push_out !== due) begin
      errors++;
      $display("FAIL push_out cyc=%0d got=%b want=%b", cyc, push_out, due);
    end
    if (push_out === 1'b1) push_seen++;
    if (due) begin
      e = sb.pop_front();
      mcnt[e.cls] = mcnt[e.cls] + 1'b1;
      last_data = e.data;
      checks++;
      if (data_out !== e.data) begin
        errors++;
        $display("FAIL data_out cyc=%0d got=%h want=%h", cyc, data_out, e.data);
      end
      checks++;
      if (cnt_o[e.cls] !== mcnt[e.cls]) begin
        errors++;
        $display("FAIL cnt%0d cyc=%0d got=%0d want=%0d", e.cls, cyc, cnt_o[e.cls], mcnt[e.cls]);
      end
    end else begin
      checks++;
      if (data_out !== last_data) begin
        errors++;
        $display("FAIL data_hold cyc=%0d got=%h want=%h", cyc, data_out, last_data);
      end
    end
    last_pop = pop;
    ps = pop;
    any = ~&empty;
    if (reset) begin
      mstate = 0;
      mptr = 0;
      sb.delete();
      for (int k = 0; k < 4; k++) mcnt[k] = '0;
      last_data = '0;
    end else begin
      if (ep != 4'd0) begin
        sb.push_back('{cls: eidx, data: fq[eidx][0], due: cyc + 2});
        mptr = (eidx + 1) % 4;
      end
      case (mstate)
        0: if (any) mstate = af ? 2 : 1;
        1: if (af) mstate = 2; else if (!any) mstate = 0;
        2: if (!af) mstate = any ? 1 : 0;
        default: mstate = 0;
      endcase
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (ps[i] && fq[i].size() > 0) din[i] = fq[i].pop_front();
    upd_empty();
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() > 0 || ~&empty) && n < 600) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 600) begin
      errors++;
      $display("FAIL drain_timeout cyc=%0d pending=%0d want=0", cyc, sb.size());
    end
    tick();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (push_out !== 1'b0 || data_out !== '0 || state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got push=%b data=%h state=%0d want 0/00/0", push_out, data_out, state);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt_o[k] !== '0) begin
        errors++;
        $display("FAIL reset_cnt%0d got=%0d want=0", k, cnt_o[k]);
      end
    end
    for (int j = 0; j < 10; j++) tick();
    checks++;
    if (pop !== 4'd0 || push_out !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL idle_empty got pop=%b push=%b state=%0d want 0000/0/0", pop, push_out, state);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] want [5];
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 4; k++) begin
      load(k, DW'(8 * k + 1));
      load(k, DW'(8 * k + 2));
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if (last_pop !== want[j]) begin
        errors++;
        $display("FAIL rr_seq step=%0d got=%b want=%b", j, last_pop, want[j]);
      end
    end
    drain();
  endtask

  task automatic test_single_class();
    logic [CW-1:0] base;
    base = mcnt[2];
    load(2, 6'h2A);
    load(2, 6'h2B);
    load(2, 6'h2C);
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (last_pop !== 4'b0100) begin
        errors++;
        $display("FAIL single_pop step=%0d got=%b want=0100", j, last_pop);
      end
    end
    drain();
    checks++;
    if (cnt_o[2] !== CW'(base + 3)) begin
      errors++;
      $display("FAIL single_cnt2 got=%0d want=%0d", cnt_o[2], base + 3);
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 4; w++) load(k, DW'(16 + 4 * k + w));
    af = 1'b0;
    for (int j = 0; j < 3; j++) tick();
    af = 1'b1;
    push_seen = 0;
    #1;
    checks++;
    if (pop !== 4'd0) begin
      errors++;
      $display("FAIL stall_pop got=%b want=0000", pop);
    end
    for (int j = 0; j < 5; j++) tick();
    checks++;
    if (push_seen > 2) begin
      errors++;
      $display("FAIL stall_pushes got=%0d want<=2", push_seen);
    end
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL stall_state got=%0d want=2", state);
    end
    af = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    load(0, 6'h11);
    load(1, 6'h12);
    load(2, 6'h13);
    tick();
    reset = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt_o[k] !== '0) begin
        errors++;
        $display("FAIL midreset_cnt%0d got=%0d want=0", k, cnt_o[k]);
      end
    end
    reset = 1'b0;
    tick();
    drain();
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int j = 0; j < 255; j++) load(1, DW'(j));
    drain();
    checks++;
    if (cnt_o[1] !== 8'd255) begin
      errors++;
      $display("FAIL wrap_pre cnt1 got=%0d want=255", cnt_o[1]);
    end
    load(1, 6'h3F);
    drain();
    checks++;
    if (cnt_o[1] !== 8'd0) begin
      errors++;
      $display("FAIL wrap_cnt1 got=%0d want=0", cnt_o[1]);
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 1) continue;
      checks++;
      if (cnt_o[k] !== '0) begin
        errors++;
        $display("FAIL wrap_other cnt%0d got=%0d want=0", k, cnt_o[k]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    af = 1'b0;
    empty = 4'hF;
    for (int i = 0; i < 4; i++) begin
      din[i] = '0;
      mcnt[i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_single_class();
    test_stall();
    test_reset_mid();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
